// File: rtl/somador_serial.sv
// somador_serial: digit-serial adder, WIDTH-bit operands added DIGIT bits per clock, LSB first.
// One DIGIT-bit adder slice is reused every cycle; the carry between digits is registered.
// Optional feature macro: SOMADOR_SUB_EN adds a 'sub' input (a - b) and an 'ovf' output.
module somador_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SOMADOR_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   soma
);

    localparam int unsigned N     = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    // Reject geometries the slice walk cannot cover exactly
    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("somador_serial: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, done_d;
    logic [WIDTH:0]   soma_d;
    logic [DIGIT:0]   slice;
`ifdef SOMADOR_SUB_EN
    logic             ovf_d;
`endif

    // Shared adder slice: lowest digit of each shifted operand plus the carry register
    assign slice = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        soma_d  = soma;
`ifdef SOMADOR_SUB_EN
        ovf_d   = ovf;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
`ifdef SOMADOR_SUB_EN
                    // Subtraction as a + ~b + 1; cin is not used
                    if (sub) begin
                        op_b_d  = ~b;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                soma_d[32'(cnt_q) * DIGIT +: DIGIT] = slice[DIGIT-1:0];
                carry_d = slice[DIGIT];
                op_a_d  = op_a_q >> DIGIT;
                op_b_d  = op_b_q >> DIGIT;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    soma_d[WIDTH] = slice[DIGIT];
`ifdef SOMADOR_SUB_EN
                    // Top digit still holds the operand sign bits here
                    ovf_d = (op_a_q[DIGIT-1] == op_b_q[DIGIT-1])
                         && (slice[DIGIT-1] != op_a_q[DIGIT-1]);
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            soma    <= '0;
`ifdef SOMADOR_SUB_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            soma    <= soma_d;
`ifdef SOMADOR_SUB_EN
            ovf     <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: a DIGIT=1 and a DIGIT=4 instance (WIDTH=8), scoreboard queues
// filled at issue time and drained by a monitor on every done pulse.
module tb_somador_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, cin1, busy1, done1;
    logic [7:0] a1, b1;
    logic [8:0] soma1;
    logic       start4, cin4, busy4, done4;
    logic [7:0] a4, b4;
    logic [8:0] soma4;
`ifdef SOMADOR_SUB_EN
    logic       sub1, ovf1, sub4, ovf4;
`endif

    typedef struct {
        logic [8:0] soma;
        logic       ovf;
        logic       sub;
        int         done_cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    // Cycle counter: value after edge k is k
    always @(posedge clk) cyc <= cyc + 1;

    somador_serial #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SOMADOR_SUB_EN
        .sub(sub1), .ovf(ovf1),
`endif
        .busy(busy1), .done(done1), .soma(soma1)
    );

    somador_serial #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SOMADOR_SUB_EN
        .sub(sub4), .ovf(ovf4),
`endif
        .busy(busy4), .done(done4), .soma(soma4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    check("d1_unexpected_done", 64'(q1.size()), 64'd1);
                end else begin
                    e1 = q1.pop_front();
                    check("d1_soma", 64'(soma1), 64'(e1.soma));
                    check("d1_latency", 64'(cyc), 64'(e1.done_cyc));
                    check("d1_busy_at_done", 64'(busy1), 64'd0);
`ifdef SOMADOR_SUB_EN
                    check(e1.sub ? "d1_ovf_sub" : "d1_ovf_add", 64'(ovf1), 64'(e1.ovf));
`endif
                end
            end
            if (done4 === 1'b1) begin
                if (q4.size() == 0) begin
                    check("d4_unexpected_done", 64'(q4.size()), 64'd1);
                end else begin
                    e4 = q4.pop_front();
                    check("d4_soma", 64'(soma4), 64'(e4.soma));
                    check("d4_latency", 64'(cyc), 64'(e4.done_cyc));
                    check("d4_busy_at_done", 64'(busy4), 64'd0);
`ifdef SOMADOR_SUB_EN
                    check(e4.sub ? "d4_ovf_sub" : "d4_ovf_add", 64'(ovf4), 64'(e4.ovf));
`endif
                end
            end
        end
    end

    // Pulse start for one cycle on the chosen instance and record the expected result
    task automatic issue(input bit sel4, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         input logic [8:0] req, input logic req_ovf);
        exp_t e;
        e.soma     = req;
        e.ovf      = req_ovf;
        e.sub      = sub;
        e.done_cyc = cyc + 1 + (sel4 ? 2 : 8);
        if (sel4) begin
            start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
`ifdef SOMADOR_SUB_EN
            sub4 = sub;
`endif
            q4.push_back(e);
        end else begin
            start1 = 1'b1; a1 = a; b1 = b; cin1 = cin;
`ifdef SOMADOR_SUB_EN
            sub1 = sub;
`endif
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Wait (bounded) until both scoreboards are drained and both instances idle
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (q1.size() == 0 && q4.size() == 0 && !busy1 && !busy4) break;
            @(posedge clk);
        end
        #1;
        check("drain_q1", 64'(q1.size()), 64'd0);
        check("drain_q4", 64'(q4.size()), 64'd0);
    endtask

    initial begin
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SOMADOR_SUB_EN
        sub1 = 1'b0; sub4 = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_done1", 64'(done1), 64'd0);
        check("rst_soma1", 64'(soma1), 64'd0);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        check("rst_soma4", 64'(soma4), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0x5A + 0x33 = 0x08D; busy for exactly 8 cycles
        issue(1'b0, 8'h5A, 8'h33, 1'b0, 1'b0, 9'h08D, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_busy_high", 64'(busy1), 64'd1);
        end
        @(negedge clk);
        check("t1_busy_low", 64'(busy1), 64'd0);
        wait_idle();

        // Full carry chain: 0xFF + 0xFF + 1 = 0x1FF
        issue(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b0);
        wait_idle();

        // DIGIT=4: carry crosses the digit boundary, 2-cycle latency
        issue(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010, 1'b0);
        wait_idle();
        issue(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b0);
        wait_idle();

        // Start during ADD is ignored; start in the done cycle is accepted
        issue(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start1 = 1'b1; a1 = 8'h00; b1 = 8'h00;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t4_done_cycle", 64'(done1), 64'd1);
        issue(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 9'h003, 1'b0);
        wait_idle();

        // Reset in the middle of an operation clears outputs at once, no done afterwards
        issue(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 9'h0FF, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy1), 64'd0);
        check("t5_rst_done", 64'(done1), 64'd0);
        check("t5_rst_soma", 64'(soma1), 64'd0);
        q1.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("t5_idle_after_rst", 64'(busy1), 64'd0);
        issue(1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 9'h100, 1'b1);
        wait_idle();

`ifdef SOMADOR_SUB_EN
        // Subtraction: borrow case and signed overflow case
        issue(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 9'h0F0, 1'b0);
        wait_idle();
        issue(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 9'h17F, 1'b1);
        wait_idle();
        issue(1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 9'h17F, 1'b1);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
